// File: rtl/sr_cmd_if.sv
// Command/drive/feedback bundle between a command source and sr_cmd_driver.
// The master side issues commands and returns q_fb; the slave side is the driver.
interface sr_cmd_if;
   logic       req_valid;
   logic       req_op;
   logic       req_ready;
   logic       s;
   logic       r;
   logic       q_fb;
   logic       done;
   logic       err;
   logic [7:0] err_cnt;

   modport master (
      output req_valid, req_op, q_fb,
      input  req_ready, s, r, done, err, err_cnt
   );

   modport slave (
      input  req_valid, req_op, q_fb,
      output req_ready, s, r, done, err, err_cnt
   );
endinterface

// File: rtl/sr_cmd_driver.sv
// Drives set/reset pulses into an external SR flip-flop, confirms the result on q_fb
// within a bounded window, then enforces an idle gap before the next command.
module sr_cmd_driver #(
   parameter int unsigned PULSE_W = 2,
   parameter int unsigned GAP_W   = 1,
   parameter int unsigned TMO     = 4
) (
   input logic     clk,
   input logic     rst_n,
   sr_cmd_if.slave bus
);

   generate
      if (PULSE_W < 1 || PULSE_W > 255) begin : g_bad_pulse_w
         $error("sr_cmd_driver: PULSE_W out of range 1..255");
      end
      if (GAP_W < 1 || GAP_W > 255) begin : g_bad_gap_w
         $error("sr_cmd_driver: GAP_W out of range 1..255");
      end
      if (TMO < 1 || TMO > 255) begin : g_bad_tmo
         $error("sr_cmd_driver: TMO out of range 1..255");
      end
   endgenerate

   // Counters load "cycles remaining minus one" so each phase exits when they hit zero.
   localparam logic [7:0] PULSE_LD = 8'(PULSE_W - 1);
   localparam logic [7:0] TMO_LD   = 8'(TMO - 1);
   localparam logic [7:0] GAP_LD   = 8'(GAP_W - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PULSE = 2'd1,
      CHECK = 2'd2,
      GAP   = 2'd3
   } state_t;

   state_t     state_q, state_d;
   logic [7:0] cnt_q, cnt_d;
   logic       op_q, op_d;
   logic       s_q, s_d;
   logic       r_q, r_d;
   logic       done_q, done_d;
   logic       err_q, err_d;
   logic [7:0] err_cnt_q, err_cnt_d;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      op_d      = op_q;
      done_d    = 1'b0;
      err_d     = 1'b0;
      err_cnt_d = err_cnt_q;

      case (state_q)
         IDLE: begin
            if (bus.req_valid) begin
               state_d = PULSE;
               op_d    = bus.req_op;
               cnt_d   = PULSE_LD;
            end
         end
         PULSE: begin
            if (cnt_q == 8'd0) begin
               state_d = CHECK;
               cnt_d   = TMO_LD;
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         CHECK: begin
            if (bus.q_fb == op_q) begin
               state_d = GAP;
               done_d  = 1'b1;
               cnt_d   = GAP_LD;
            end else if (cnt_q == 8'd0) begin
               state_d = GAP;
               err_d   = 1'b1;
               cnt_d   = GAP_LD;
               if (err_cnt_q != 8'hFF) begin
                  err_cnt_d = err_cnt_q + 8'd1;
               end
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         GAP: begin
            if (cnt_q == 8'd0) begin
               state_d = IDLE;
               cnt_d   = 8'd0;
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = 8'd0;
         end
      endcase

      // s and r come from one decoded condition with opposite polarity, so they cannot overlap.
      s_d = (state_d == PULSE) &&  op_d;
      r_d = (state_d == PULSE) && !op_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         cnt_q     <= 8'd0;
         op_q      <= 1'b0;
         s_q       <= 1'b0;
         r_q       <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
         err_cnt_q <= 8'd0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         op_q      <= op_d;
         s_q       <= s_d;
         r_q       <= r_d;
         done_q    <= done_d;
         err_q     <= err_d;
         err_cnt_q <= err_cnt_d;
      end
   end

   assign bus.req_ready = (state_q == IDLE);
   assign bus.s         = s_q;
   assign bus.r         = r_q;
   assign bus.done      = done_q;
   assign bus.err       = err_q;
   assign bus.err_cnt   = err_cnt_q;

endmodule
